// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Free-running unsigned restoring divider. Samples a/b, then
//                produces one quotient bit per clock and publishes registered
//                quotient (opt) and remainder (low) every WIDTH+2 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module divider #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] opt,
  output logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_t;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic             w_last;
  logic             w_unused_rem_msb;

  // Trial remainder: previous remainder shifted left with the next dividend bit.
  assign w_t    = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_ge   = (w_t >= {1'b0, r_dvs});
  assign w_diff = w_t - {1'b0, r_dvs};
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // After each restoring step the remainder is below the divisor, so its top
  // bit is always zero and only the lower WIDTH bits feed the next trial.
  assign w_unused_rem_msb = r_rem[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Next-state logic: LOAD once, CALC for WIDTH iterations, DONE once.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  // Datapath: operand capture, shift-subtract iterations and result publish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      opt   <= '0;
      low   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_dvd <= a;
          r_dvs <= b;
          r_rem <= '0;
          r_q   <= '0;
          r_cnt <= '0;
        end
        S_CALC: begin
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem <= w_ge ? w_diff : w_t;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_DONE: begin
          opt <= r_q;
          low <= r_rem[WIDTH-1:0];
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Self-checking bench for divider: directed table, corner
//                sequences (mid-CALC operand change, mid-period reset),
//                random pairs and an exhaustive operand sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divider;

  localparam int WIDTH = 5;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] opt;
  logic [WIDTH-1:0] low;

  int compared = 0;
  int failed   = 0;

  // Last published result, which outputs must hold between DONE edges.
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] hold_r;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
  } vec_t;

  vec_t tbl [10];

  divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .opt   (opt),
    .low   (low),
    .a     (a),
    .b     (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic, with divide-by-zero giving all ones and a.
  function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int ix = int'(x);
    int iy = int'(y);
    if (iy == 0) return {WIDTH{1'b1}};
    return WIDTH'(ix / iy);
  endfunction

  function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int ix = int'(x);
    int iy = int'(y);
    if (iy == 0) return x;
    return WIDTH'(ix % iy);
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
    compared++;
    if (opt !== eq || low !== er) begin
      failed++;
      $display("FAIL %s (t=%0t): got opt=%0d low=%0d, expected opt=%0d low=%0d",
               nm, $time, opt, low, eq, er);
    end
  endtask

  // One full period starting just before a LOAD edge; checks outputs hold
  // the previous result for WIDTH+1 edges, then show the new one.
  task automatic run_period(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                            input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                            input string nm);
    a = ta;
    b = tb_;
    for (int e = 1; e <= WIDTH + 2; e++) begin
      @(posedge clk);
      #1;
      if (e < WIDTH + 2) chk({nm, "_hold"}, hold_q, hold_r);
    end
    chk(nm, eq, er);
    hold_q = eq;
    hold_r = er;
  endtask

  initial begin
    tbl[0] = '{a: 5'd7,  b: 5'd5,  q: 5'd1,  r: 5'd2};
    tbl[1] = '{a: 5'd31, b: 5'd1,  q: 5'd31, r: 5'd0};
    tbl[2] = '{a: 5'd3,  b: 5'd7,  q: 5'd0,  r: 5'd3};
    tbl[3] = '{a: 5'd20, b: 5'd0,  q: 5'd31, r: 5'd20};
    tbl[4] = '{a: 5'd0,  b: 5'd9,  q: 5'd0,  r: 5'd0};
    tbl[5] = '{a: 5'd30, b: 5'd4,  q: 5'd7,  r: 5'd2};
    tbl[6] = '{a: 5'd9,  b: 5'd2,  q: 5'd4,  r: 5'd1};
    tbl[7] = '{a: 5'd31, b: 5'd31, q: 5'd1,  r: 5'd0};
    tbl[8] = '{a: 5'd0,  b: 5'd0,  q: 5'd31, r: 5'd0};
    tbl[9] = '{a: 5'd17, b: 5'd3,  q: 5'd5,  r: 5'd2};

    // Reset held low across clock edges; outputs must read zero.
    reset = 1'b0;
    a = 5'd7;
    b = 5'd5;
    #3;
    chk("reset_async", 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_held", 5'd0, 5'd0);
    reset = 1'b1;
    hold_q = '0;
    hold_r = '0;

    // First period: zero through edge 6, result at edge 7, then stable.
    run_period(5'd7, 5'd5, 5'd1, 5'd2, "first");
    run_period(5'd7, 5'd5, 5'd1, 5'd2, "first_repeat");

    // Directed table.
    for (int i = 0; i < 10; i++)
      run_period(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("tbl%0d", i));

    // Operands change during CALC: ignored until the next LOAD.
    a = 5'd7;
    b = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    a = 5'd30;
    b = 5'd4;
    repeat (WIDTH + 2 - 3) @(posedge clk);
    #1;
    chk("midcalc_first", 5'd1, 5'd2);
    hold_q = 5'd1;
    hold_r = 5'd2;
    run_period(5'd30, 5'd4, 5'd7, 5'd2, "midcalc_second");

    // Reset mid-computation clears outputs with no clock edge.
    a = 5'd31;
    b = 5'd1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_async", 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_held", 5'd0, 5'd0);
    @(negedge clk);
    reset = 1'b1;
    hold_q = '0;
    hold_r = '0;
    run_period(5'd9, 5'd2, 5'd4, 5'd1, "after_reset");

    // Randomized pairs against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom_range(0, 31));
      rb = WIDTH'($urandom_range(0, 31));
      run_period(ra, rb, ref_q(ra, rb), ref_r(ra, rb), $sformatf("rand_%0d_%0d", ra, rb));
    end

    // Exhaustive sweep, one pair per period.
    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        run_period(WIDTH'(x), WIDTH'(y), ref_q(WIDTH'(x), WIDTH'(y)), ref_r(WIDTH'(x), WIDTH'(y)),
                   $sformatf("sweep_%0d_%0d", x, y));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/divider.md
Name: divider

Overview:
- Unsigned sequential restoring divider: computes quotient and remainder of a / b, one quotient bit per clock.
- Free-running: after reset it repeatedly samples a and b, computes, and publishes registered results, with no start/done handshake.
- Standalone arithmetic leaf block clocked by the system clock.

Parameters:
- WIDTH, 5, operand/result bit width. The iteration count equals WIDTH, and one full computation period is WIDTH+2 cycles.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- opt  output  WIDTH  registered quotient of the last completed division
- low  output  WIDTH  registered remainder of the last completed division
- a  input  WIDTH  dividend, unsigned
- b  input  WIDTH  divisor, unsigned

Behaviour:
- Reset (reset=0, asynchronous): opt=0, low=0, state=LOAD, internal dividend/divisor/remainder/quotient/counter registers = 0. Holding reset low keeps the block in this condition regardless of clk.
- The FSM has three states: LOAD, CALC and DONE.
- LOAD (1 cycle), on the rising edge:
  - capture a into dvd and b into dvs;
  - clear the partial remainder rem (WIDTH+1 bits) and the quotient shift register q;
  - set counter=0; next state is CALC.
- CALC (WIDTH cycles), on each rising edge:
  - form t = {rem[WIDTH-1:0], dvd[WIDTH-1]} and shift dvd left by 1;
  - if t >= {1'b0,dvs}: rem = t - dvs and shift 1 into q LSB;
  - otherwise: rem = t and shift 0 into q LSB;
  - increment counter; after the WIDTH-th iteration, next state is DONE.
- DONE (1 cycle), on the rising edge:
  - opt <= q and low <= rem[WIDTH-1:0];
  - next state is LOAD.
- Latency: the first rising edge after reset deasserts is the LOAD edge, and opt/low update on the (WIDTH+2)th edge, i.e. the 7th edge for WIDTH=5. New results then appear every WIDTH+2 cycles.
- opt and low change only on the DONE edge and hold stable for the rest of the period. Glitch-free registered outputs are required.
- Changes to a or b outside the LOAD edge are ignored until the next LOAD.
- Divide by zero (captured b=0) is not special-cased in the datapath. It naturally yields opt=all ones (5'h1F) and low=a, and this result is required.
- Range: a=0 gives opt=0 and low=0 for any b≠0; a<b gives opt=0 and low=a; b=1 gives opt=a and low=0.
- Reset asserted mid-CALC or mid-DONE: outputs clear immediately (asynchronously), the computation in flight is discarded, and the block restarts with LOAD after release.
- Arithmetic is unsigned. rem is WIDTH+1 bits wide so the comparison cannot overflow. No other widths are truncated.

Test Plan:
- a=7, b=5, hold reset low 1 cycle then release -> opt=0, low=0 through edge 6; at edge 7 opt=1, low=2; values stable through the next period.
- a=31, b=1 -> opt=31, low=0 after 7 edges; a=3, b=7 -> opt=0, low=3.
- a=20, b=0 -> opt=31, low=20 (divide-by-zero convention).
- a=7, b=5, then change to a=30, b=4 at edge 3 (during CALC) -> first result opt=1, low=2; next period (edge 14) opt=7, low=2.
- Assert reset low at edge 4 mid-computation -> opt=0 and low=0 immediately without a clock edge; after release with a=9, b=2 -> opt=4, low=1 at the 7th edge.
- Exhaustive sweep of all a,b in 0..31, one operand pair per 7-cycle period -> opt==a/b and low==a%b for b≠0; opt=31 and low=a for b=0.
